// File: rtl/led_fade_sequencer.sv
// led_fade_sequencer
//
// Feeds the LED PWM stage with a slowly slewing 6-bit duty reference. A target
// brightness is accepted over a valid/ready handshake. The level then moves one
// LSB toward that target every (step_div+1) cycles, which gives smooth fades.
//
// Build option:
//   LED_FADE_GAMMA_EN - when defined, level_out follows a quadratic perceptual
//                       curve, (cur*cur + 2^LEVEL_W-1) >> LEVEL_W.
//                       When undefined, level_out = cur (linear).
//                       The state machine, handshake and timing are the same in
//                       both builds.
//
// Ports:
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   tgt_level  in   LEVEL_W  requested brightness
//   step_div   in   DIV_W    cycles per step minus one, sampled at accept
//   tgt_valid  in   1        target request valid
//   tgt_ready  out  1        high only while idle; a request is accepted when
//                            valid and ready are both high
//   abort      in   1        stops an active fade and holds the current level
//   level_out  out  LEVEL_W  duty reference for the PWM stage
//   busy       out  1        a fade is in progress
//   done       out  1        1-cycle pulse when a fade completes normally
module led_fade_sequencer #(
  parameter int LEVEL_W = 6,
  parameter int DIV_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] tgt_level,
  input  logic [DIV_W-1:0]   step_div,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  input  logic               abort,
  output logic [LEVEL_W-1:0] level_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_t;

  state_t             state;
  logic [LEVEL_W-1:0] cur;
  logic [LEVEL_W-1:0] tgt;
  logic [DIV_W-1:0]   div;
  logic [DIV_W-1:0]   tick;
  logic [LEVEL_W-1:0] cur_step;

  // Quadratic brightness curve. The sum needs 2*LEVEL_W+1 bits. The shifted
  // result always fits back into LEVEL_W bits.
  function automatic logic [LEVEL_W-1:0] gamma_map(input logic [LEVEL_W-1:0] v);
    logic [2*LEVEL_W:0] sq;
    sq = ((2*LEVEL_W+1)'(v) * (2*LEVEL_W+1)'(v)) + (2*LEVEL_W+1)'((2**LEVEL_W) - 1);
    return LEVEL_W'(sq >> LEVEL_W);
  endfunction

  // Value cur takes when a step fires in the current ramp direction.
  assign cur_step = (state == RAMP_UP) ? cur + LEVEL_W'(1) : cur - LEVEL_W'(1);

  assign tgt_ready = (state == IDLE);
  assign busy      = !tgt_ready;

`ifdef LED_FADE_GAMMA_EN
  assign level_out = gamma_map(cur);
`else
  assign level_out = cur;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      tgt   <= '0;
      div   <= '0;
      tick  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // abort has no effect here.
          if (tgt_valid) begin
            tgt  <= tgt_level;
            div  <= step_div;
            tick <= '0;
            if (tgt_level > cur) begin
              state <= RAMP_UP;
            end else if (tgt_level < cur) begin
              state <= RAMP_DOWN;
            end else begin
              // Already at the target: complete immediately.
              done <= 1'b1;
            end
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (abort) begin
            // abort wins over a step on the same edge; cur is frozen.
            state <= IDLE;
            tick  <= '0;
          end else if (tick != div) begin
            tick <= tick + DIV_W'(1);
          end else begin
            tick <= '0;
            cur  <= cur_step;
            // cur starts strictly on one side of tgt and moves one LSB at a
            // time, so it lands exactly on tgt and never wraps.
            if (cur_step == tgt) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tick  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Testbench for led_fade_sequencer: directed scenarios plus randomized fades.
// Each fade is compared against a closed-form reference: k cycles after the
// accept edge the level has moved min(N, k/(D+1)) LSBs toward the target, and
// done fires exactly at k = N*(D+1).
module tb_led_fade_sequencer;

  localparam int LEVEL_W = 6;
  localparam int DIV_W   = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic [LEVEL_W-1:0] tgt_level;
  logic [DIV_W-1:0]   step_div;
  logic               tgt_valid;
  logic               tgt_ready;
  logic               abort;
  logic [LEVEL_W-1:0] level_out;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;
  int mcur   = 0;

  led_fade_sequencer #(.LEVEL_W(LEVEL_W), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_level (tgt_level),
    .step_div  (step_div),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .abort     (abort),
    .level_out (level_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Brightness the PWM stage should see for an internal level v.
  function automatic int map_level(input int v);
`ifdef LED_FADE_GAMMA_EN
    return (v * v + (1 << LEVEL_W) - 1) >> LEVEL_W;
`else
    return v;
`endif
  endfunction

  // Level k cycles after the accept edge of a fade c -> t with divisor d.
  function automatic int lvl_at(input int c, input int t, input int d, input int k);
    int n;
    int s;
    n = (t > c) ? t - c : c - t;
    s = k / (d + 1);
    if (s > n) s = n;
    return (t >= c) ? c + s : c - s;
  endfunction

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int t, input int d);
    check("ready_before_accept", tgt_ready, 1);
    tgt_level = LEVEL_W'(t);
    step_div  = DIV_W'(d);
    tgt_valid = 1'b1;
    tick_edge();
    tgt_valid = 1'b0;
    tgt_level = LEVEL_W'($urandom);
    step_div  = DIV_W'($urandom);
  endtask

  // Follows a fade from just after its accept edge. ka >= 0 asserts abort
  // after the check at cycle ka. hold stops at the done cycle so the caller
  // can observe a back-to-back accept.
  task automatic track(input int t, input int d, input int ka, input bit hold);
    int c, n, total, last, el, eb, ed;
    c     = mcur;
    n     = (t > c) ? t - c : c - t;
    total = n * (d + 1);
    last  = (ka >= 0) ? ka + 1 : (hold ? total : total + 1);
    for (int k = 0; k <= last; k++) begin
      if (ka >= 0 && k > ka) begin
        el = lvl_at(c, t, d, ka);
        eb = 0;
        ed = 0;
      end else begin
        el = lvl_at(c, t, d, k);
        eb = (k < total) ? 1 : 0;
        ed = (k == total) ? 1 : 0;
      end
      check("level", level_out, map_level(el));
      check("busy", busy, eb);
      check("done", done, ed);
      check("ready", tgt_ready, (eb == 0) ? 1 : 0);
      if (k == ka) abort = 1'b1;
      if (k < last) begin
        tick_edge();
        abort = 1'b0;
      end
    end
    mcur = (ka >= 0) ? lvl_at(c, t, d, ka) : t;
  endtask

  initial begin
    int t, d, ka, n;
    rst       = 1'b1;
    tgt_level = '0;
    step_div  = '0;
    tgt_valid = 1'b0;
    abort     = 1'b0;

    // Reset held for two cycles.
    tick_edge();
    tick_edge();
    check("rst_level", level_out, 0);
    check("rst_ready", tgt_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst  = 1'b0;
    mcur = 0;

    // Ramp up 0 -> 10, one step every 4 cycles, done at cycle 40.
    accept(10, 3);
    track(10, 3, -1, 1'b0);

    // Full-scale ramps: up to 63, then down to 0 one step per cycle.
    accept(63, 0);
    track(63, 0, -1, 1'b0);
    accept(0, 0);
    track(0, 0, -1, 1'b0);

    // Equal target: no movement, done on the next cycle.
    accept(0, 2);
    track(0, 2, -1, 1'b0);
    accept(7, 0);
    track(7, 0, -1, 1'b0);
    accept(7, 1);
    track(7, 1, -1, 1'b0);

    // Abort at level 5 of a 0 -> 20 fade, then ramp down to 2.
    accept(0, 0);
    track(0, 0, -1, 1'b0);
    accept(20, 1);
    track(20, 1, 10, 1'b0);
    check("abort_hold_level", mcur, 5);
    accept(2, 0);
    track(2, 0, -1, 1'b0);

    // abort while idle is ignored.
    abort = 1'b1;
    tick_edge();
    abort = 1'b0;
    check("idle_abort_level", level_out, map_level(mcur));
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);

    // tgt_valid held through a fade: the request waits, then is taken on the
    // first idle cycle, which is also the done cycle.
    accept(3, 0);
    tgt_valid = 1'b1;
    tgt_level = LEVEL_W'(12);
    step_div  = DIV_W'(1);
    track(3, 0, -1, 1'b1);
    tick_edge();
    tgt_valid = 1'b0;
    track(12, 1, -1, 1'b0);

    // Mid-scale point of the brightness curve.
    accept(32, 0);
    track(32, 0, -1, 1'b0);
`ifdef LED_FADE_GAMMA_EN
    check("gamma_32", level_out, 16);
`else
    check("linear_32", level_out, 32);
`endif

    // Reset in the middle of a fade.
    accept(50, 2);
    repeat (5) tick_edge();
    rst = 1'b1;
    tick_edge();
    check("midrst_level", level_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", tgt_ready, 1);
    rst  = 1'b0;
    mcur = 0;
    tick_edge();
    check("post_rst_done", done, 0);

    // Randomized fades, some with an abort at a random cycle.
    for (int i = 0; i < 10; i++) begin
      t  = int'($urandom_range(0, 63));
      d  = int'($urandom_range(0, 3));
      n  = (t > mcur) ? t - mcur : mcur - t;
      ka = -1;
      if (n > 0 && $urandom_range(0, 2) == 0) ka = int'($urandom_range(0, n * (d + 1) - 1));
      accept(t, d);
      track(t, d, ka, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
